cache_ctrl: RTL and testbench

Read-only, direct-mapped cache controller that sequences the 512-set dual-port tag/data SRAM array: accepts 32-bit CPU read requests, performs tag lookup, and on a miss fetches a 64-byte line from memory in eight 64-bit beats, writes it into the array and returns the requested word. Sits between the CPU load port and the memory read channel; the SRAM array instance is external and driven directly by this block.

---
 rtl/cache_pkg.sv | 29 ++
 rtl/cache_fill_buf.sv | 41 ++++
 rtl/cache_ctrl.sv | 147 ++++++++++++++
 tb/tb_cache_ctrl.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_pkg.sv
// Shared widths, tag-entry layout and controller state encoding for the
// direct-mapped read-only cache.
package cache_pkg;
  localparam int TAG_W  = 17;
  localparam int IDX_W  = 9;
  localparam int OFF_W  = 6;
  localparam int LINE_W = 512;
  localparam int BEATS  = 8;
  localparam int BEAT_W = 64;
  localparam int CNT_W  = 3;

  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] tag;
  } tag_entry_t;

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    MISS_REQ,
    MISS_FILL,
    FILL_WR
  } state_t;

  // 32-bit word w of a 512-bit line
  function automatic logic [31:0] word_sel(input logic [LINE_W-1:0] line, input logic [3:0] w);
    return line[{w, 5'b0} +: 32];
  endfunction
endpackage

// File: rtl/cache_fill_buf.sv
// Line assembly buffer: stores eight 64-bit beats in arrival order and flags
// the beat that completes the line.
module cache_fill_buf
  import cache_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              beat_valid,
  input  logic [BEAT_W-1:0] beat_data,
  output logic [LINE_W-1:0] line,
  output logic              done
);
  logic [CNT_W-1:0]  cnt_reg;
  logic [BEAT_W-1:0] beats_reg [BEATS];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_reg <= '0;
    end else if (clear) begin
      cnt_reg <= '0;
    end else if (beat_valid) begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

  // Payload needs no reset: the counter alone decides what is meaningful.
  always_ff @(posedge clk) begin
    if (beat_valid && !clear) begin
      beats_reg[cnt_reg] <= beat_data;
    end
  end

  assign done = beat_valid && !clear && (cnt_reg == CNT_W'(BEATS - 1));

  generate
    for (genvar gi = 0; gi < BEATS; gi++) begin : g_line
      assign line[gi*BEAT_W +: BEAT_W] = beats_reg[gi];
    end
  endgenerate
endmodule

// File: rtl/cache_ctrl.sv
// Direct-mapped read-only cache controller driving an external tag/data SRAM.
// Optional hit/miss counters are enabled with CACHE_STATS_EN.
module cache_ctrl
  import cache_pkg::*;
#(
  parameter int CPU_AW = 32,
  parameter int MEM_DW = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic [CPU_AW-1:0] req_addr_i,
  output logic              resp_valid_o,
  output logic [31:0]       resp_data_o,
  output logic              mem_arvalid_o,
  input  logic              mem_arready_i,
  output logic [CPU_AW-1:0] mem_araddr_o,
  input  logic              mem_rvalid_i,
  input  logic [MEM_DW-1:0] mem_rdata_i,
  output logic              sram_rden_o,
  output logic [IDX_W-1:0]  sram_raddr_o,
  input  logic [TAG_W:0]    sram_rdata_tag_i,
  input  logic [LINE_W-1:0] sram_rdata_data_i,
  output logic              sram_wren_o,
  output logic [IDX_W-1:0]  sram_waddr_o,
  output logic [TAG_W:0]    sram_wdata_tag_o,
  output logic [LINE_W-1:0] sram_wdata_data_o
`ifdef CACHE_STATS_EN
  ,
  output logic [31:0]       stat_hit_o,
  output logic [31:0]       stat_miss_o
`endif
);
  state_t            state_reg, state_next;
  logic [TAG_W-1:0]  tag_reg;
  logic [IDX_W-1:0]  idx_reg;
  logic [3:0]        word_reg;
  logic              hit_pulse_reg;
  logic [31:0]       resp_data_reg;
  logic              fill_clear, fill_beat, fill_done;
  logic [LINE_W-1:0] fill_line;
  tag_entry_t        rd_entry;
  logic              hit, req_fire, unused_bits;

  assign unused_bits = ^req_addr_i[1:0];
  assign rd_entry    = tag_entry_t'(sram_rdata_tag_i);
  assign hit         = rd_entry.valid && (rd_entry.tag == tag_reg);
  assign req_ready_o = rst_n && (state_reg == IDLE);
  assign req_fire    = req_valid_i && req_ready_o;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      tag_reg       <= '0;
      idx_reg       <= '0;
      word_reg      <= '0;
      hit_pulse_reg <= 1'b0;
      resp_data_reg <= '0;
    end else begin
      state_reg     <= state_next;
      hit_pulse_reg <= (state_reg == LOOKUP) && hit;
      if (req_fire) begin
        tag_reg  <= req_addr_i[31:15];
        idx_reg  <= req_addr_i[14:6];
        word_reg <= req_addr_i[5:2];
      end
      // Array output exists only in LOOKUP, so the hit word is captured there.
      if ((state_reg == LOOKUP) && hit) begin
        resp_data_reg <= word_sel(sram_rdata_data_i, word_reg);
      end
    end
  end

  always_comb begin
    state_next        = state_reg;
    sram_rden_o       = 1'b0;
    sram_raddr_o      = '0;
    mem_arvalid_o     = 1'b0;
    sram_wren_o       = 1'b0;
    sram_waddr_o      = '0;
    sram_wdata_tag_o  = '0;
    sram_wdata_data_o = '0;
    fill_clear        = 1'b0;
    fill_beat         = 1'b0;
    case (state_reg)
      IDLE: begin
        if (req_fire) begin
          sram_rden_o  = 1'b1;
          sram_raddr_o = req_addr_i[14:6];
          state_next   = LOOKUP;
        end
      end
      LOOKUP:   state_next = hit ? IDLE : MISS_REQ;
      MISS_REQ: begin
        mem_arvalid_o = 1'b1;
        if (mem_arready_i) begin
          fill_clear = 1'b1;
          state_next = MISS_FILL;
        end
      end
      MISS_FILL: begin
        fill_beat = mem_rvalid_i;
        if (fill_done) state_next = FILL_WR;
      end
      FILL_WR: begin
        sram_wren_o       = 1'b1;
        sram_waddr_o      = idx_reg;
        sram_wdata_tag_o  = {1'b1, tag_reg};
        sram_wdata_data_o = fill_line;
        state_next        = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign mem_araddr_o = {tag_reg, idx_reg, 6'b0};
  assign resp_valid_o = hit_pulse_reg || (state_reg == FILL_WR);
  assign resp_data_o  = (state_reg == FILL_WR) ? word_sel(fill_line, word_reg) : resp_data_reg;

  cache_fill_buf u_fill_buf (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (fill_clear),
    .beat_valid (fill_beat),
    .beat_data  (mem_rdata_i),
    .line       (fill_line),
    .done       (fill_done)
  );

`ifdef CACHE_STATS_EN
  logic [31:0] stat_hit_reg, stat_miss_reg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stat_hit_reg  <= '0;
      stat_miss_reg <= '0;
    end else if (state_reg == LOOKUP) begin
      if (hit && !(&stat_hit_reg))        stat_hit_reg  <= stat_hit_reg + 1'b1;
      else if (!hit && !(&stat_miss_reg)) stat_miss_reg <= stat_miss_reg + 1'b1;
    end
  end

  assign stat_hit_o  = stat_hit_reg;
  assign stat_miss_o = stat_miss_reg;
`endif
endmodule

// File: tb/tb_cache_ctrl.sv
// Randomized bench for cache_ctrl: external SRAM and memory models plus a
// reference cache built from per-index valid/tag arrays.
module tb_cache_ctrl;
  logic         clk, rst_n;
  logic         req_valid, req_ready;
  logic [31:0]  req_addr;
  logic         resp_valid;
  logic [31:0]  resp_data;
  logic         mem_arvalid, mem_arready, mem_rvalid;
  logic [31:0]  mem_araddr;
  logic [63:0]  mem_rdata;
  logic         sram_rden, sram_wren;
  logic [8:0]   sram_raddr, sram_waddr;
  logic [17:0]  sram_rdata_tag, sram_wdata_tag;
  logic [511:0] sram_rdata_data, sram_wdata_data;
`ifdef CACHE_STATS_EN
  logic [31:0]  stat_hit, stat_miss;
`endif

  int total = 0;
  int bad   = 0;

  bit          ref_valid [512];
  logic [16:0] ref_tag   [512];
  int          n_hit, n_miss;

  logic [17:0]  arr_tag  [512];
  logic [511:0] arr_data [512];

  cache_ctrl dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .req_valid_i       (req_valid),
    .req_ready_o       (req_ready),
    .req_addr_i        (req_addr),
    .resp_valid_o      (resp_valid),
    .resp_data_o       (resp_data),
    .mem_arvalid_o     (mem_arvalid),
    .mem_arready_i     (mem_arready),
    .mem_araddr_o      (mem_araddr),
    .mem_rvalid_i      (mem_rvalid),
    .mem_rdata_i       (mem_rdata),
    .sram_rden_o       (sram_rden),
    .sram_raddr_o      (sram_raddr),
    .sram_rdata_tag_i  (sram_rdata_tag),
    .sram_rdata_data_i (sram_rdata_data),
    .sram_wren_o       (sram_wren),
    .sram_waddr_o      (sram_waddr),
    .sram_wdata_tag_o  (sram_wdata_tag),
    .sram_wdata_data_o (sram_wdata_data)
`ifdef CACHE_STATS_EN
    ,
    .stat_hit_o        (stat_hit),
    .stat_miss_o       (stat_miss)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External array: registered read, garbage on cycles without a read.
  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 512; i++) arr_tag[i] <= '0;
    end else if (sram_wren) begin
      arr_tag[sram_waddr]  <= sram_wdata_tag;
      arr_data[sram_waddr] <= sram_wdata_data;
    end
    if (sram_rden) begin
      sram_rdata_tag  <= arr_tag[sram_raddr];
      sram_rdata_data <= arr_data[sram_raddr];
    end else begin
      sram_rdata_tag  <= 18'($urandom);
      sram_rdata_data <= {16{$urandom}};
    end
  end

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hC0FF_EE11;
  endfunction

  function automatic logic [63:0] mem_beat(input logic [31:0] line, input int k);
    return {mem_word(line + 32'(8 * k) + 32'd4), mem_word(line + 32'(8 * k))};
  endfunction

  function automatic logic [511:0] mem_line(input logic [31:0] line);
    logic [511:0] l;
    for (int w = 0; w < 16; w++) l[w*32 +: 32] = mem_word(line + 32'(4 * w));
    return l;
  endfunction

  task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ref_reset();
    for (int i = 0; i < 512; i++) ref_valid[i] = 1'b0;
    n_hit  = 0;
    n_miss = 0;
  endtask

  task automatic chk_rst(input string pfx);
    chk({pfx, "_ctl"}, {req_ready, resp_valid, resp_data, mem_arvalid, mem_araddr, sram_rden,
                        sram_raddr, sram_wren, sram_waddr, sram_wdata_tag}, '0);
    chk({pfx, "_line"}, sram_wdata_data, '0);
  endtask

  // One CPU read; abort_at >= 0 pulls rst_n during that fill beat.
  task automatic do_read(input logic [31:0] addr, input int ar_delay, input int abort_at);
    logic [8:0]  idx;
    logic [16:0] tag;
    logic [31:0] line, exp_data, ar_first, got_data;
    logic [8:0]  wr_a;
    logic [17:0] wr_t;
    logic [511:0] wr_l;
    logic        wr_en_s, rdy_s;
    bit exp_hit, got, ar_seen, ar_hs, fill, ar_ok, rdy_ok, wr_ok, aborted;
    int n, resp_cyc, last_cyc, ar_wait, gap, k;
    idx = addr[14:6];
    tag = addr[31:15];
    line = {addr[31:6], 6'b0};
    exp_hit = ref_valid[idx] && (ref_tag[idx] == tag);
    exp_data = mem_word({addr[31:2], 2'b0});
    got = 0; ar_seen = 0; ar_hs = 0; fill = 0; ar_ok = 1; rdy_ok = 1; wr_ok = 1; aborted = 0;
    resp_cyc = 0; last_cyc = -10; ar_wait = 0; k = 0; ar_first = '0; got_data = '0;
    wr_a = '0; wr_t = '0; wr_l = '0; wr_en_s = 0; rdy_s = 0;
    gap = $urandom_range(0, 2);

    tick();
    chk("pulse_end", {resp_valid, sram_wren}, 2'b00);
    req_valid = 1'b1;
    req_addr  = addr;
    #1;
    n = 0;
    while (!req_ready && n < 20) begin
      tick();
      #1;
      n++;
    end
    chk("req_rdy", req_ready, 1'b1);
    chk("rden", sram_rden, 1'b1);
    chk("raddr", sram_raddr, idx);
    tick();
    req_valid = 1'b0;
    req_addr  = $urandom;
    if (exp_hit) n_hit++; else n_miss++;

    for (int cyc = 1; cyc <= 300 && !got && !aborted; cyc++) begin
      if (resp_valid) begin
        got = 1; resp_cyc = cyc; got_data = resp_data; rdy_s = req_ready;
        wr_en_s = sram_wren; wr_a = sram_waddr; wr_t = sram_wdata_tag; wr_l = sram_wdata_data;
      end else begin
        if (req_ready) rdy_ok = 0;
        if (sram_wren) wr_ok = 0;
        if (mem_arvalid) begin
          if (!ar_seen) ar_first = mem_araddr;
          else if (mem_araddr != ar_first) ar_ok = 0;
          ar_seen = 1;
        end else if (ar_seen && !ar_hs) begin
          ar_ok = 0;
        end
        if (ar_hs) fill = 1;
        mem_arready = mem_arvalid && (ar_wait >= ar_delay);
        if (mem_arvalid) ar_wait++;
        if (mem_arvalid && mem_arready) ar_hs = 1;
        if (fill && k < 8 && gap > 0) begin
          gap--;
          mem_rvalid = 1'b0;
          mem_rdata  = {$urandom, $urandom};
        end else if (fill && k < 8) begin
          mem_rvalid = 1'b1;
          mem_rdata  = mem_beat(line, k);
          if (k == abort_at) begin
            rst_n = 1'b0;
            aborted = 1;
          end
          k++;
          last_cyc = cyc;
        end else begin
          mem_rvalid = 1'($urandom);
          mem_rdata  = {$urandom, $urandom};
        end
        tick();
      end
    end
    mem_arready = 1'b0;
    mem_rvalid  = 1'b0;

    if (aborted) begin
      chk_rst("abort_rst");
      rst_n = 1'b1;
      ref_reset();
      for (int j = k; j < 8; j++) begin
        mem_rvalid = 1'b1;
        mem_rdata  = mem_beat(line, j);
        tick();
      end
      mem_rvalid = 1'b0;
      $display("rd %h aborted by reset after %0d beats", addr, k);
    end else begin
      chk("resp_seen", got, 1'b1);
      chk("data", got_data, exp_data);
      chk("rdy_low", rdy_ok, 1'b1);
      chk("wr_spur", wr_ok, 1'b1);
      if (exp_hit) begin
        chk("hit_lat", resp_cyc, 2);
        chk("hit_noar", ar_seen, 1'b0);
        chk("hit_rdy", rdy_s, 1'b1);
        chk("hit_nowr", wr_en_s, 1'b0);
      end else begin
        chk("ar_addr", ar_first, line);
        chk("ar_stable", ar_ok, 1'b1);
        chk("miss_lat", resp_cyc, last_cyc + 1);
        chk("wr_en", wr_en_s, 1'b1);
        chk("wr_addr", wr_a, idx);
        chk("wr_tag", wr_t, {1'b1, tag});
        chk("wr_line", wr_l, mem_line(line));
        chk("miss_rdy", rdy_s, 1'b0);
        ref_valid[idx] = 1'b1;
        ref_tag[idx]   = tag;
      end
      $display("rd %h %s lat=%0d data=%h exp=%h", addr, exp_hit ? "hit" : "miss",
               resp_cyc, got_data, exp_data);
    end
  endtask

  initial begin
    logic [8:0] idx_pool [4];
    logic [31:0] a;
    idx_pool[0] = 9'h041; idx_pool[1] = 9'h042; idx_pool[2] = 9'h1FF; idx_pool[3] = 9'h000;
    rst_n = 1'b0; req_valid = 1'b0; req_addr = '0;
    mem_arready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    ref_reset();
    repeat (3) tick();
    chk_rst("reset");
    rst_n = 1'b1;
    #1;
    chk("idle_rdy", req_ready, 1'b1);

    do_read(32'h0000_1040, 1, -1);
    do_read(32'h0000_1044, 0, -1);
    do_read(32'h0000_9040, 0, -1);
    do_read(32'h0000_1040, 5, -1);
`ifdef CACHE_STATS_EN
    chk("stat_hit", stat_hit, 32'(n_hit));
    chk("stat_miss", stat_miss, 32'(n_miss));
`endif
    do_read(32'h0000_2080, 2, 3);
    do_read(32'h0000_2080, 0, -1);

    for (int t = 0; t < 40; t++) begin
      a = {15'($urandom_range(0, 3)), 2'b0, idx_pool[$urandom_range(0, 3)], 6'($urandom)};
      do_read(a, $urandom_range(0, 3), -1);
    end
`ifdef CACHE_STATS_EN
    chk("stat_hit_end", stat_hit, 32'(n_hit));
    chk("stat_miss_end", stat_miss, 32'(n_miss));
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
